// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC sequencer: FSM state encoding, frame field
// positions and the request-to-frame packing helper.
package dac_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_TRIG = 3'd2,
      ST_WAIT = 3'd3,
      ST_GAP  = 3'd4
   } dac_state_t;

   localparam int FRAME_W      = 32;
   localparam int ENTRY_W      = 20;
   localparam int FRM_CMD_LSB  = 20;
   localparam int FRM_ADDR_LSB = 16;
   localparam int FRM_DATA_LSB = 4;

   // FIFO entry layout is {cmd[3:0], addr[3:0], data[11:0]}
   function automatic logic [FRAME_W-1:0] build_frame(input logic [ENTRY_W-1:0] entry);
      logic [FRAME_W-1:0] f;
      f = '0;
      f[FRM_CMD_LSB  +: 4]  = entry[19:16];
      f[FRM_ADDR_LSB +: 4]  = entry[15:12];
      f[FRM_DATA_LSB +: 12] = entry[11:0];
      return f;
   endfunction

endpackage

// File: rtl/dac_req_fifo.sv
// Synchronous request FIFO (power-of-two depth) with full/empty flags and a
// registered ready that never depends combinationally on the push request.
module dac_req_fifo
   import dac_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = ENTRY_W
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_ready;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_ready = r_ready;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + 1'b1;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // ready is held low in reset and follows the next occupancy afterwards
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_nxt;
         r_ready <= (w_count_nxt != CW'(DEPTH));
      end
   end

endmodule

// File: rtl/dac_seq.sv
// DAC frame sequencer: queues requests, launches SPI frames with a guard gap.
// Optional echo readback check is built when DAC_SEQ_READBACK_EN is defined.
//
// state | meaning
// IDLE  | waiting for a queued request
// LOAD  | pop FIFO, register frame
// TRIG  | one-cycle start pulse to SPI engine
// WAIT  | frame in flight, wait for spi_done
// GAP   | enforced idle time before next frame
module dac_seq
   import dac_seq_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 4
) (
   input  logic             CLK50MHZ,
   input  logic             RST,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_cmd,
   input  logic [3:0]       req_addr,
   input  logic [11:0]      req_data,
   output logic [WIDTH-1:0] spi_data_in,
   output logic             spi_trig,
   input  logic             spi_done,
   input  logic [WIDTH-1:0] spi_data_out,
   output logic             busy,
   output logic [15:0]      xfer_count,
   input  logic             rb_clear,
   output logic             rb_error
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   dac_state_t         r_state;
   logic [WIDTH-1:0]   r_frame;
   logic               r_trig;
   logic [GW-1:0]      r_gap_cnt;
   logic [15:0]        r_xfer_cnt;

   logic               w_fifo_ready;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic [ENTRY_W-1:0] w_fifo_data;
   logic               w_push;
   logic               w_pop;
   logic               w_done_ok;
   logic [WIDTH-1:0]   w_frame;

   assign w_push    = req_valid && w_fifo_ready;
   assign w_pop     = (r_state == ST_LOAD);
   assign w_done_ok = (r_state == ST_WAIT) && spi_done;
   assign w_frame   = WIDTH'(build_frame(w_fifo_data));

   dac_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (ENTRY_W)
   ) u_fifo (
      .i_clk   (CLK50MHZ),
      .i_rst_n (RST),
      .i_push  (w_push),
      .i_data  ({req_cmd, req_addr, req_data}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_ready (w_fifo_ready)
   );

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         r_state    <= ST_IDLE;
         r_frame    <= '0;
         r_trig     <= 1'b0;
         r_gap_cnt  <= '0;
         r_xfer_cnt <= '0;
      end else begin
         r_trig <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_fifo_empty) begin
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_frame <= w_frame;
               r_trig  <= 1'b1;
               r_state <= ST_TRIG;
            end
            ST_TRIG: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_done_ok) begin
                  r_xfer_cnt <= r_xfer_cnt + 16'd1;
                  r_gap_cnt  <= GW'(GAP_CYCLES - 1);
                  r_state    <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = w_fifo_ready;
   assign spi_data_in = r_frame;
   assign spi_trig    = r_trig;
   assign busy        = (r_state != ST_IDLE) || !w_fifo_empty;
   assign xfer_count  = r_xfer_cnt;

`ifdef DAC_SEQ_READBACK_EN
   logic [WIDTH-1:0] r_prev_frame;
   logic             r_prev_valid;
   logic             r_rb_error;

   // the DAC echoes the previous frame, so the first frame has nothing to match
   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         r_prev_frame <= '0;
         r_prev_valid <= 1'b0;
         r_rb_error   <= 1'b0;
      end else begin
         if (w_done_ok) begin
            r_prev_frame <= r_frame;
            r_prev_valid <= 1'b1;
         end
         if (w_done_ok && r_prev_valid && (spi_data_out != r_prev_frame)) begin
            r_rb_error <= 1'b1;
         end else if (rb_clear) begin
            r_rb_error <= 1'b0;
         end
      end
   end

   assign rb_error = r_rb_error;
`else
   logic w_unused;
   assign w_unused = &{1'b0, rb_clear, spi_data_out, w_fifo_full};
   assign rb_error = 1'b0;
`endif

endmodule

// File: tb/tb_dac_seq.sv
// Directed bench for dac_seq: vector table plus hand-written corner sequences.
module tb_dac_seq;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int GAP   = 4;
`ifdef DAC_SEQ_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   logic             CLK50MHZ = 1'b0;
   logic             RST = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [3:0]       req_cmd = '0;
   logic [3:0]       req_addr = '0;
   logic [11:0]      req_data = '0;
   logic [WIDTH-1:0] spi_data_in;
   logic             spi_trig;
   logic             spi_done = 1'b0;
   logic [WIDTH-1:0] spi_data_out = '0;
   logic             busy;
   logic [15:0]      xfer_count;
   logic             rb_clear = 1'b0;
   logic             rb_error;

   dac_seq #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (DEPTH),
      .GAP_CYCLES (GAP)
   ) dut (
      .CLK50MHZ     (CLK50MHZ),
      .RST          (RST),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_cmd      (req_cmd),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .spi_data_in  (spi_data_in),
      .spi_trig     (spi_trig),
      .spi_done     (spi_done),
      .spi_data_out (spi_data_out),
      .busy         (busy),
      .xfer_count   (xfer_count),
      .rb_clear     (rb_clear),
      .rb_error     (rb_error)
   );

   always #10 CLK50MHZ = ~CLK50MHZ;

   typedef struct {
      logic [3:0]  cmd;
      logic [3:0]  addr;
      logic [11:0] data;
      logic [31:0] frame;
   } vec_t;

   vec_t        vecs [4];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] trig_q [$];
   int          trig_cyc_q [$];
   int          done_cyc_q [$];
   logic [31:0] last_frame = '0;
   logic [15:0] exp_xfer = '0;

   always @(posedge CLK50MHZ) cyc <= cyc + 1;

   always @(negedge CLK50MHZ) begin
      if (spi_trig) begin
         trig_q.push_back(spi_data_in);
         trig_cyc_q.push_back(cyc);
      end
      if (spi_done) done_cyc_q.push_back(cyc);
   end

   function automatic logic [31:0] mk_frame(input logic [3:0] c, input logic [3:0] a,
                                             input logic [11:0] d);
      return {8'h00, c, a, d, 4'h0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge CLK50MHZ);
      #1;
   endtask

   task automatic clear_mon();
      trig_q.delete();
      trig_cyc_q.delete();
      done_cyc_q.delete();
   endtask

   // called one step after a rising edge; returns one step after the accepting edge
   task automatic send_req(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d,
                           output int acc);
      bit ok;
      ok = 1'b0;
      req_cmd = c;
      req_addr = a;
      req_data = d;
      req_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK50MHZ);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      sync();
      acc = cyc;
      req_valid = 1'b0;
      if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_trigs(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (trig_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(negedge CLK50MHZ);
      end
      sync();
      if (!ok) check("trig_timeout", trig_q.size(), n);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK50MHZ);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      sync();
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_done(input logic [31:0] echo, input logic clr);
      spi_done = 1'b1;
      spi_data_out = echo;
      rb_clear = clr;
      sync();
      spi_done = 1'b0;
      rb_clear = 1'b0;
   endtask

   task automatic do_done(input logic [31:0] cur, input bit corrupt, input logic clr);
      pulse_done(last_frame ^ {31'd0, corrupt}, clr);
      last_frame = cur;
      exp_xfer = exp_xfer + 16'd1;
   endtask

   task automatic run_frame(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d,
                            input bit corrupt, input logic clr);
      int acc;
      logic [31:0] f;
      f = mk_frame(c, a, d);
      clear_mon();
      send_req(c, a, d, acc);
      wait_trigs(1);
      check("run_frame", trig_q[0], f);
      do_done(f, corrupt, clr);
      check("run_xfer", xfer_count, exp_xfer);
      wait_idle();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      logic [31:0] e [6];

      vecs[0] = '{4'h3, 4'h0, 12'hABC, 32'h0030ABC0};
      vecs[1] = '{4'hF, 4'hF, 12'hFFF, 32'h00FFFFF0};
      vecs[2] = '{4'h0, 4'h0, 12'h000, 32'h00000000};
      vecs[3] = '{4'hA, 4'h5, 12'h123, 32'h00A51230};

      // reset values
      repeat (2) @(negedge CLK50MHZ);
      check("rst_ready", req_ready, 0);
      check("rst_trig", spi_trig, 0);
      check("rst_data_in", spi_data_in, 0);
      check("rst_busy", busy, 0);
      check("rst_xfer", xfer_count, 0);
      check("rst_rb", rb_error, 0);
      RST = 1'b1;
      #1;
      check("ready_before_edge", req_ready, 0);
      @(negedge CLK50MHZ);
      check("ready_first_edge", req_ready, 1);
      sync();

      // table-driven single requests
      for (int i = 0; i < 4; i++) begin
         clear_mon();
         send_req(vecs[i].cmd, vecs[i].addr, vecs[i].data, acc);
         wait_trigs(1);
         check("vec_frame", trig_q[0], vecs[i].frame);
         check("vec_latency", trig_cyc_q[0] - acc, 2);
         check("vec_busy_wait", busy, 1);
         repeat (3) sync();
         check("vec_hold", spi_data_in, vecs[i].frame);
         check("vec_one_trig", trig_q.size(), 1);
         do_done(vecs[i].frame, 1'b0, 1'b0);
         check("vec_xfer", xfer_count, exp_xfer);
         check("vec_rb", rb_error, 0);
         wait_idle();
         check("vec_hold_idle", spi_data_in, vecs[i].frame);
      end

      // spi_done while idle is ignored
      clear_mon();
      pulse_done(32'hDEAD_BEEF, 1'b0);
      repeat (6) sync();
      check("idle_done_xfer", xfer_count, exp_xfer);
      check("idle_done_busy", busy, 0);
      check("idle_done_trig", trig_q.size(), 0);
      check("idle_done_rb", rb_error, 0);

      // five back-to-back requests with spi_done withheld, then a sixth held at full
      clear_mon();
      for (int k = 0; k < 6; k++) e[k] = mk_frame(4'(k + 1), 4'(k), 12'h100 + 12'(k));
      for (int k = 0; k < 5; k++) send_req(4'(k + 1), 4'(k), 12'h100 + 12'(k), acc);
      req_cmd = 4'h6;
      req_addr = 4'h5;
      req_data = 12'h105;
      req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK50MHZ);
         check("full_ready_low", req_ready, 0);
      end
      check("full_one_trig", trig_q.size(), 1);
      sync();
      fork
         begin
            int acc6;
            send_req(4'h6, 4'h5, 12'h105, acc6);
         end
         begin
            for (int k = 0; k < 6; k++) begin
               wait_trigs(k + 1);
               do_done(e[k], 1'b0, 1'b0);
            end
         end
      join
      wait_idle();
      check("drain_count", trig_q.size(), 6);
      for (int k = 0; k < 6; k++) check("drain_order", trig_q[k], e[k]);
      for (int k = 1; k < 6; k++)
         check("drain_gap", trig_cyc_q[k] - done_cyc_q[k - 1] - 1, GAP + 2);
      check("drain_xfer", xfer_count, exp_xfer);
      check("drain_ready", req_ready, 1);

      // reset during WAIT, late spi_done, then a fresh request
      clear_mon();
      send_req(4'h9, 4'h1, 12'h777, acc);
      wait_trigs(1);
      check("pre_rst_busy", busy, 1);
      @(negedge CLK50MHZ);
      RST = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_trig", spi_trig, 0);
      check("mid_rst_data", spi_data_in, 0);
      check("mid_rst_ready", req_ready, 0);
      check("mid_rst_xfer", xfer_count, 0);
      check("mid_rst_rb", rb_error, 0);
      exp_xfer = '0;
      last_frame = '0;
      @(negedge CLK50MHZ);
      RST = 1'b1;
      @(negedge CLK50MHZ);
      check("rerst_ready", req_ready, 1);
      sync();
      pulse_done(32'h0000_0001, 1'b0);
      repeat (4) sync();
      check("late_done_xfer", xfer_count, 0);
      check("late_done_busy", busy, 0);
      clear_mon();
      send_req(4'h5, 4'h2, 12'h5A5, acc);
      wait_trigs(1);
      check("post_rst_frame", trig_q[0], 32'h00525A50);
      check("post_rst_latency", trig_cyc_q[0] - acc, 2);
      do_done(32'h00525A50, 1'b1, 1'b0);
      check("post_rst_xfer", xfer_count, 1);
      check("first_frame_no_cmp", rb_error, 0);
      wait_idle();

      // counter wrap from 16'hFFFF
      force dut.r_xfer_cnt = 16'hFFFF;
      @(negedge CLK50MHZ);
      release dut.r_xfer_cnt;
      check("preload_xfer", xfer_count, 16'hFFFF);
      sync();
      exp_xfer = 16'hFFFF;
      run_frame(4'h1, 4'h2, 12'h345, 1'b0, 1'b0);
      check("wrap_xfer", xfer_count, 16'h0000);

      // readback compare (expected flag is zero when the check is not built)
      run_frame(4'h2, 4'h3, 12'h456, 1'b0, 1'b0);
      check("rb_match", rb_error, 0);
      run_frame(4'h3, 4'h4, 12'h567, 1'b1, 1'b0);
      check("rb_mismatch", rb_error, RB_EN);
      run_frame(4'h4, 4'h5, 12'h678, 1'b0, 1'b0);
      check("rb_sticky", rb_error, RB_EN);
      rb_clear = 1'b1;
      sync();
      rb_clear = 1'b0;
      check("rb_cleared", rb_error, 0);
      run_frame(4'h5, 4'h6, 12'h789, 1'b1, 1'b1);
      check("rb_set_wins", rb_error, RB_EN);
      rb_clear = 1'b1;
      sync();
      rb_clear = 1'b0;
      check("rb_cleared2", rb_error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
